axi_id_remap_ctrl: RTL and testbench

- Controller for the ID-width-narrowing stage of the AXI converter chain, type_1 to type_2.
- Maps wide source IDs onto 2**DST_IW destination ID slots and tracks outstanding transactions per slot.
- Stalls new requests when no legal slot exists.
- Returns the original source ID when a response comes back.
- One instance per direction: AW/B and AR/R.

---
 rtl/axi_converter_pkg.sv | 28 ++
 rtl/axi_id_remap_ctrl_if.sv | 33 +++
 rtl/axi_id_remap_slot.sv | 64 ++++++
 rtl/axi_id_remap_ctrl.sv | 123 ++++++++++++
 tb/tb_axi_id_remap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_converter_pkg.sv
// Shared definitions for the AXI converter chain.
// Holds the default ID-remap configuration, the slot record type, and helper functions
// that derive the slot count and the per-slot counter width from the block parameters.
package axi_converter_pkg;

    // Counter width able to hold the values 0..n inclusive.
    function automatic int unsigned clog2_plus1(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Number of destination ID slots addressable with dst_iw bits.
    function automatic int unsigned num_slots(input int unsigned dst_iw);
        return 32'd1 << dst_iw;
    endfunction

    localparam int unsigned DefSrcIw   = 8;
    localparam int unsigned DefDstIw   = 2;
    localparam int unsigned DefMaxTxns = 8;
    localparam int unsigned DefCw      = clog2_plus1(DefMaxTxns);

    // Per-slot tracking record in the default configuration.
    typedef struct packed {
        logic                valid;
        logic [DefSrcIw-1:0] src_id;
        logic [DefCw-1:0]    count;
    } slot_t;

endpackage

// File: rtl/axi_id_remap_ctrl_if.sv
// Request/response bus of the ID remap controller.
// slave  : the controller (takes alloc/free requests, returns mapping and status).
// master : the datapath driving requests and consuming the mapping.
// Signals:
//   alloc_valid_i / alloc_src_id_i  -> offered AW/AR request and its wide source ID
//   alloc_ready_o / alloc_dst_id_o  <- acceptance and chosen narrow destination ID
//   free_valid_i  / free_dst_id_i   -> final response beat and its destination ID
//   free_src_id_o                   <- restored source ID for that response
//   busy_o / err_o                  <- any slot outstanding / sticky underflow error
interface axi_id_remap_ctrl_if #(
    parameter int unsigned SRC_IW = 8,
    parameter int unsigned DST_IW = 2
) ();
    logic              alloc_valid_i;
    logic [SRC_IW-1:0] alloc_src_id_i;
    logic              alloc_ready_o;
    logic [DST_IW-1:0] alloc_dst_id_o;
    logic              free_valid_i;
    logic [DST_IW-1:0] free_dst_id_i;
    logic [SRC_IW-1:0] free_src_id_o;
    logic              busy_o;
    logic              err_o;

    modport slave (
        input  alloc_valid_i, alloc_src_id_i, free_valid_i, free_dst_id_i,
        output alloc_ready_o, alloc_dst_id_o, free_src_id_o, busy_o, err_o
    );

    modport master (
        output alloc_valid_i, alloc_src_id_i, free_valid_i, free_dst_id_i,
        input  alloc_ready_o, alloc_dst_id_o, free_src_id_o, busy_o, err_o
    );
endinterface

// File: rtl/axi_id_remap_slot.sv
// One destination-ID slot: valid flag, owning source ID and outstanding count.
// Ports:
//   clk_i, srst_i    clock, synchronous active-high reset
//   load_i           claim the (free) slot for load_src_id_i with count 1
//   inc_i / dec_i    count up / down; both together leave the count unchanged
//   cmp_src_id_i     source ID to compare against the owner
//   match_o          slot is valid and owned by cmp_src_id_i
//   valid_o, src_id_o, count_o   registered state
module axi_id_remap_slot #(
    parameter int unsigned SRC_IW = 8,
    parameter int unsigned CW     = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              load_i,
    input  logic [SRC_IW-1:0] load_src_id_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic [SRC_IW-1:0] cmp_src_id_i,
    output logic              match_o,
    output logic              valid_o,
    output logic [SRC_IW-1:0] src_id_o,
    output logic [CW-1:0]     count_o
);
    logic              valid_q, valid_d;
    logic [SRC_IW-1:0] src_id_q, src_id_d;
    logic [CW-1:0]     count_q, count_d;

    // load only targets an invalid slot (count 0), so it never overlaps dec.
    always_comb begin
        valid_d  = valid_q;
        src_id_d = src_id_q;
        count_d  = count_q;
        if (load_i) begin
            valid_d  = 1'b1;
            src_id_d = load_src_id_i;
            count_d  = CW'(1);
        end else if (inc_i && !dec_i) begin
            count_d = count_q + CW'(1);
        end else if (dec_i && !inc_i) begin
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            valid_q  <= 1'b0;
            src_id_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            src_id_q <= src_id_d;
            count_q  <= count_d;
        end
    end

    assign match_o  = valid_q && (src_id_q == cmp_src_id_i);
    assign valid_o  = valid_q;
    assign src_id_o = src_id_q;
    assign count_o  = count_q;
endmodule

// File: rtl/axi_id_remap_ctrl.sv
// ID-width-narrowing controller: maps wide source IDs onto 2**DST_IW destination slots,
// counts outstanding transactions per slot and restores the source ID on response.
// One instance serves one direction (AW/B or AR/R).
// Ports:
//   clk_i   clock
//   srst_i  synchronous active-high reset; forces alloc_ready_o low while asserted
//   bus     axi_id_remap_ctrl_if.slave request/response/status bundle
module axi_id_remap_ctrl
    import axi_converter_pkg::*;
#(
    parameter int unsigned SRC_IW   = DefSrcIw,
    parameter int unsigned DST_IW   = DefDstIw,
    parameter int unsigned MAX_TXNS = DefMaxTxns
) (
    input  logic              clk_i,
    input  logic              srst_i,
    axi_id_remap_ctrl_if.slave bus
);
    localparam int unsigned NUM_SLOTS = num_slots(DST_IW);
    localparam int unsigned CW        = clog2_plus1(MAX_TXNS);
    localparam logic [CW-1:0] MaxCnt  = CW'(MAX_TXNS);

    logic [NUM_SLOTS-1:0] slot_valid;
    logic [NUM_SLOTS-1:0] slot_match;
    logic [NUM_SLOTS-1:0] slot_inc;
    logic [NUM_SLOTS-1:0] slot_dec;
    logic [NUM_SLOTS-1:0] slot_load;
    logic [SRC_IW-1:0]    slot_src_id [NUM_SLOTS];
    logic [CW-1:0]        slot_count  [NUM_SLOTS];

    logic              hit;
    logic [DST_IW-1:0] hit_idx;
    logic              any_free;
    logic [DST_IW-1:0] free_idx;
    logic              alloc_ready;
    logic              accept;
    logic              release_err;
    logic              busy;
    logic              err_q, err_d;

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        axi_id_remap_slot #(
            .SRC_IW (SRC_IW),
            .CW     (CW)
        ) u_slot (
            .clk_i         (clk_i),
            .srst_i        (srst_i),
            .load_i        (slot_load[g]),
            .load_src_id_i (bus.alloc_src_id_i),
            .inc_i         (slot_inc[g]),
            .dec_i         (slot_dec[g]),
            .cmp_src_id_i  (bus.alloc_src_id_i),
            .match_o       (slot_match[g]),
            .valid_o       (slot_valid[g]),
            .src_id_o      (slot_src_id[g]),
            .count_o       (slot_count[g])
        );
    end

    // Lookup works on registered state only, so a same-cycle release never frees a
    // slot or unstalls a saturated hit until the following cycle.
    always_comb begin
        hit     = |slot_match;
        hit_idx = '0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            if (slot_match[i]) begin
                hit_idx = DST_IW'(i);
            end
        end
        any_free = ~&slot_valid;
        free_idx = '0;
        // Descending scan so the lowest-index invalid slot wins.
        for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
            if (!slot_valid[i]) begin
                free_idx = DST_IW'(i);
            end
        end
    end

    always_comb begin
        alloc_ready = 1'b0;
        if (srst_i) begin
            alloc_ready = 1'b0;
        end else if (hit) begin
            alloc_ready = slot_count[hit_idx] < MaxCnt;
        end else begin
            alloc_ready = any_free;
        end
    end

    assign accept = bus.alloc_valid_i && alloc_ready;

    always_comb begin
        slot_inc  = '0;
        slot_load = '0;
        slot_dec  = '0;
        busy      = 1'b0;
        for (int i = 0; i < int'(NUM_SLOTS); i++) begin
            slot_inc[i]  = accept && hit && (hit_idx == DST_IW'(i));
            slot_load[i] = accept && !hit && (free_idx == DST_IW'(i));
            slot_dec[i]  = bus.free_valid_i && (bus.free_dst_id_i == DST_IW'(i)) &&
                           (slot_count[i] != '0);
            busy         = busy || (slot_count[i] != '0);
        end
    end

    assign release_err = bus.free_valid_i && (slot_count[bus.free_dst_id_i] == '0);
    assign err_d       = err_q || release_err;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.alloc_ready_o  = alloc_ready;
    assign bus.alloc_dst_id_o = hit ? hit_idx : free_idx;
    assign bus.free_src_id_o  = slot_src_id[bus.free_dst_id_i];
    assign bus.busy_o         = busy;
    assign bus.err_o          = err_q;
endmodule

// File: tb/tb_axi_id_remap_ctrl.sv
module tb_axi_id_remap_ctrl;
    logic clk;
    logic srst;
    int   checks;
    int   errors;

    axi_id_remap_ctrl_if #(.SRC_IW(8), .DST_IW(2)) bus ();

    axi_id_remap_ctrl #(
        .SRC_IW   (8),
        .DST_IW   (2),
        .MAX_TXNS (8)
    ) dut (
        .clk_i  (clk),
        .srst_i (srst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; inputs change and outputs settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_valid_i  = 1'b0;
        bus.alloc_src_id_i = '0;
        bus.free_valid_i   = 1'b0;
        bus.free_dst_id_i  = '0;
    endtask

    task automatic do_reset();
        idle();
        srst = 1'b1;
        tick();
        srst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        srst = 1'b1;
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_src_id_i = 8'h5A;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", bus.alloc_ready_o);
        end
        tick();
        srst = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: busy %b err %b want 0 0", bus.busy_o, bus.err_o);
        end
    endtask

    task automatic test_first_alloc();
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_src_id_i = 8'h5A;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'd0) begin
            errors++;
            $display("FAIL first_alloc: ready %b dst %0d want 1 0",
                     bus.alloc_ready_o, bus.alloc_dst_id_o);
        end
        tick();
        bus.alloc_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.busy_o !== 1'b1 || dut.slot_count[0] !== 4'd1) begin
            errors++;
            $display("FAIL first_alloc_state: busy %b count0 %0d want 1 1",
                     bus.busy_o, dut.slot_count[0]);
        end
    endtask

    // Slot 0 already holds 0x5A with count 1.
    task automatic test_saturate();
        for (int k = 1; k < 8; k++) begin
            bus.alloc_valid_i  = 1'b1;
            bus.alloc_src_id_i = 8'h5A;
            #1;
            checks++;
            if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'd0) begin
                errors++;
                $display("FAIL sat_accept%0d: ready %b dst %0d want 1 0",
                         k, bus.alloc_ready_o, bus.alloc_dst_id_o);
            end
            tick();
        end
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0 || dut.slot_count[0] !== 4'd8) begin
            errors++;
            $display("FAIL sat_ninth: ready %b count0 %0d want 0 8",
                     bus.alloc_ready_o, dut.slot_count[0]);
        end
        bus.free_valid_i  = 1'b1;
        bus.free_dst_id_i = 2'd0;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0 || bus.free_src_id_o !== 8'h5A) begin
            errors++;
            $display("FAIL sat_same_cycle: ready %b src %h want 0 5a",
                     bus.alloc_ready_o, bus.free_src_id_o);
        end
        tick();
        bus.free_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b1 || dut.slot_count[0] !== 4'd7) begin
            errors++;
            $display("FAIL sat_next_cycle: ready %b count0 %0d want 1 7",
                     bus.alloc_ready_o, dut.slot_count[0]);
        end
        idle();
    endtask

    task automatic test_four_ids();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            bus.alloc_valid_i  = 1'b1;
            bus.alloc_src_id_i = 8'(k + 1);
            #1;
            checks++;
            if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'(k)) begin
                errors++;
                $display("FAIL four_ids%0d: ready %b dst %0d want 1 %0d",
                         k, bus.alloc_ready_o, bus.alloc_dst_id_o, k);
            end
            tick();
        end
        bus.alloc_src_id_i = 8'h05;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0 || bus.alloc_dst_id_o !== 2'd0) begin
            errors++;
            $display("FAIL fifth_full: ready %b dst %0d want 0 0",
                     bus.alloc_ready_o, bus.alloc_dst_id_o);
        end
        bus.free_valid_i  = 1'b1;
        bus.free_dst_id_i = 2'd1;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0 || bus.free_src_id_o !== 8'h02) begin
            errors++;
            $display("FAIL fifth_drain_cycle: ready %b src %h want 0 02",
                     bus.alloc_ready_o, bus.free_src_id_o);
        end
        tick();
        bus.free_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'd1) begin
            errors++;
            $display("FAIL fifth_after_drain: ready %b dst %0d want 1 1",
                     bus.alloc_ready_o, bus.alloc_dst_id_o);
        end
        tick();
        bus.alloc_valid_i = 1'b0;
        bus.free_dst_id_i = 2'd1;
        #1;
        checks++;
        if (dut.slot_count[1] !== 4'd1 || bus.free_src_id_o !== 8'h05) begin
            errors++;
            $display("FAIL fifth_state: count1 %0d src %h want 1 05",
                     dut.slot_count[1], bus.free_src_id_o);
        end
    endtask

    // Slot 2 holds 0x03 with count 1 from the previous scenario.
    task automatic test_same_cycle();
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_src_id_i = 8'h03;
        bus.free_valid_i   = 1'b1;
        bus.free_dst_id_i  = 2'd2;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'd2 ||
            bus.free_src_id_o !== 8'h03) begin
            errors++;
            $display("FAIL same_cycle_comb: ready %b dst %0d src %h want 1 2 03",
                     bus.alloc_ready_o, bus.alloc_dst_id_o, bus.free_src_id_o);
        end
        tick();
        bus.alloc_valid_i = 1'b0;
        bus.free_valid_i  = 1'b0;
        #1;
        checks++;
        // All slots are valid, so ready for 0x03 proves slot 2 is still owned by it.
        if (dut.slot_count[2] !== 4'd1 || bus.alloc_ready_o !== 1'b1 ||
            bus.alloc_dst_id_o !== 2'd2 || bus.err_o !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_state: count2 %0d ready %b dst %0d err %b want 1 1 2 0",
                     dut.slot_count[2], bus.alloc_ready_o, bus.alloc_dst_id_o, bus.err_o);
        end
        idle();
    endtask

    task automatic test_err();
        do_reset();
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_src_id_i = 8'h10;
        tick();
        bus.alloc_valid_i = 1'b0;
        bus.free_valid_i  = 1'b1;
        bus.free_dst_id_i = 2'd3;
        tick();
        bus.free_valid_i = 1'b0;
        #1;
        checks++;
        if (bus.err_o !== 1'b1 || dut.slot_count[0] !== 4'd1 || dut.slot_count[3] !== 4'd0) begin
            errors++;
            $display("FAIL err_set: err %b count0 %0d count3 %0d want 1 1 0",
                     bus.err_o, dut.slot_count[0], dut.slot_count[3]);
        end
        tick();
        tick();
        checks++;
        if (bus.err_o !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky: got %b want 1", bus.err_o);
        end
        do_reset();
        checks++;
        if (bus.err_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL err_cleared: err %b busy %b want 0 0", bus.err_o, bus.busy_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_src_id_i = 8'h11;
        tick();
        bus.alloc_src_id_i = 8'h22;
        tick();
        bus.alloc_src_id_i = 8'h33;
        srst = 1'b1;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got %b want 0", bus.alloc_ready_o);
        end
        tick();
        srst = 1'b0;
        bus.alloc_src_id_i = 8'h77;
        #1;
        checks++;
        if (bus.alloc_ready_o !== 1'b1 || bus.alloc_dst_id_o !== 2'd0) begin
            errors++;
            $display("FAIL post_reset_alloc: ready %b dst %0d want 1 0",
                     bus.alloc_ready_o, bus.alloc_dst_id_o);
        end
        tick();
        bus.alloc_valid_i = 1'b0;
        #1;
        checks++;
        if (dut.slot_count[0] !== 4'd1 || dut.slot_count[1] !== 4'd0 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_state: count0 %0d count1 %0d busy %b want 1 0 1",
                     dut.slot_count[0], dut.slot_count[1], bus.busy_o);
        end
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        srst   = 1'b1;
        idle();
        tick();
        test_reset();
        test_first_alloc();
        test_saturate();
        test_four_ids();
        test_same_cycle();
        test_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
